// File: rtl/sha256_job_scheduler.sv
// Job queue and dispatcher for a bank of SHA-256 engines with round-robin completion return.
// Optional per-job watchdog enabled by defining SHA_SCHED_TIMEOUT_EN.
module sha256_job_scheduler #(
    parameter int NUM_CORES      = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            job_valid,
    output logic                            job_ready,
    input  logic [15:0]                     job_msg_addr,
    input  logic [15:0]                     job_out_addr,
    output logic [NUM_CORES-1:0]            core_start,
    output logic [16*NUM_CORES-1:0]         core_msg_addr,
    output logic [16*NUM_CORES-1:0]         core_out_addr,
    input  logic [NUM_CORES-1:0]            core_done,
    output logic                            cpl_valid,
    input  logic                            cpl_ready,
    output logic [$clog2(NUM_CORES)-1:0]    cpl_core,
    output logic [15:0]                     cpl_out_addr,
    output logic                            cpl_error,
    output logic [$clog2(FIFO_DEPTH):0]     pending,
    output logic                            busy
);

    localparam int CW = $clog2(NUM_CORES);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ACK,
        S_RUN,
        S_CPL
    } state_t;

    state_t state     [NUM_CORES];
    state_t state_nxt [NUM_CORES];

    logic [15:0] q_msg [FIFO_DEPTH];
    logic [15:0] q_out [FIFO_DEPTH];
    logic [PW:0] wr_ptr, rd_ptr;
    logic        empty, full, push;

    logic [15:0] eng_msg [NUM_CORES];
    logic [15:0] eng_out [NUM_CORES];

    logic [CW-1:0]        disp_ptr, disp_grant, d_idx;
    logic [CW-1:0]        cpl_ptr, cpl_grant, c_idx;
    logic                 disp_any, cpl_any, hs;
    logic [NUM_CORES-1:0] elig, cand, tmo, err, not_idle;

    function automatic logic [CW-1:0] inc(input logic [CW-1:0] p);
        return (p == CW'(NUM_CORES - 1)) ? '0 : p + CW'(1);
    endfunction

    assign pending   = wr_ptr - rd_ptr;
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (pending == (PW+1)'(FIFO_DEPTH));
    assign job_ready = !full;
    assign push      = job_valid && job_ready;
    assign hs        = cpl_valid && cpl_ready;
    assign busy      = !empty || (|not_idle);

    always_comb begin
        elig       = '0;
        cand       = '0;
        not_idle   = '0;
        core_start = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            elig[i]       = !empty && (state[i] == S_IDLE) && core_done[i];
            // exclude the engine already on the completion port
            cand[i]       = (state[i] == S_CPL) &&
                            !(cpl_valid && (cpl_core == CW'(i)));
            not_idle[i]   = (state[i] != S_IDLE);
            core_start[i] = (state[i] == S_START);
            core_msg_addr[16*i +: 16] = eng_msg[i];
            core_out_addr[16*i +: 16] = eng_out[i];
        end
    end

    always_comb begin
        disp_any   = 1'b0;
        disp_grant = '0;
        d_idx      = disp_ptr;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (!disp_any && elig[d_idx]) begin
                disp_any   = 1'b1;
                disp_grant = d_idx;
            end
            d_idx = inc(d_idx);
        end
    end

    // on a handshake the pointer moves past the winner in the same cycle
    always_comb begin
        cpl_any   = 1'b0;
        cpl_grant = '0;
        c_idx     = hs ? inc(cpl_core) : cpl_ptr;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (!cpl_any && cand[c_idx]) begin
                cpl_any   = 1'b1;
                cpl_grant = c_idx;
            end
            c_idx = inc(c_idx);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            state_nxt[i] = state[i];
            unique case (state[i])
                S_IDLE:  if (disp_any && disp_grant == CW'(i))
                             state_nxt[i] = S_START;
                S_START: state_nxt[i] = S_ACK;
                S_ACK:   if (tmo[i])             state_nxt[i] = S_CPL;
                         else if (!core_done[i]) state_nxt[i] = S_RUN;
                S_RUN:   if (core_done[i] || tmo[i])
                             state_nxt[i] = S_CPL;
                S_CPL:   if (hs && cpl_core == CW'(i))
                             state_nxt[i] = S_IDLE;
                default: state_nxt[i] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CORES; i++) state[i] <= S_IDLE;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) state[i] <= state_nxt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_msg[wr_ptr[PW-1:0]] <= job_msg_addr;
            q_out[wr_ptr[PW-1:0]] <= job_out_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            disp_ptr     <= '0;
            cpl_ptr      <= '0;
            cpl_valid    <= 1'b0;
            cpl_core     <= '0;
            cpl_out_addr <= '0;
            cpl_error    <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                eng_msg[i] <= '0;
                eng_out[i] <= '0;
            end
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (disp_any) begin
                rd_ptr              <= rd_ptr + 1'b1;
                eng_msg[disp_grant] <= q_msg[rd_ptr[PW-1:0]];
                eng_out[disp_grant] <= q_out[rd_ptr[PW-1:0]];
                disp_ptr            <= inc(disp_grant);
            end
            if (hs) cpl_ptr <= inc(cpl_core);
            if (cpl_any && (!cpl_valid || hs)) begin
                cpl_valid    <= 1'b1;
                cpl_core     <= cpl_grant;
                cpl_out_addr <= eng_out[cpl_grant];
                cpl_error    <= err[cpl_grant];
            end else if (hs) begin
                cpl_valid <= 1'b0;
            end
        end
    end

`ifdef SHA_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tcnt [NUM_CORES];

    always_comb begin
        tmo = '0;
        for (int i = 0; i < NUM_CORES; i++)
            tmo[i] = ((state[i] == S_ACK) || (state[i] == S_RUN)) &&
                     (tcnt[i] == TW'(TIMEOUT_CYCLES - 1));
    end

    // a normal finish on the limit cycle wins over the watchdog
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= '0;
            for (int i = 0; i < NUM_CORES; i++) tcnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (state[i] == S_START) begin
                    tcnt[i] <= '0;
                    err[i]  <= 1'b0;
                end else if (state[i] == S_ACK || state[i] == S_RUN) begin
                    tcnt[i] <= tcnt[i] + 1'b1;
                    if (tmo[i] && !(state[i] == S_RUN && core_done[i]))
                        err[i] <= 1'b1;
                end
            end
        end
    end
`else
    assign tmo = '0;
    assign err = '0;
`endif

endmodule

// File: tb/tb_sha256_job_scheduler.sv
// Directed bench for sha256_job_scheduler with a behavioural engine model.
// Watchdog sequence runs only when SHA_SCHED_TIMEOUT_EN is defined.
module tb_sha256_job_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [15:0] job_msg_addr = '0;
    logic [15:0] job_out_addr = '0;
    logic [3:0]  core_start;
    logic [63:0] core_msg_addr, core_out_addr;
    logic [3:0]  core_done;
    logic        cpl_valid;
    logic        cpl_ready = 1'b1;
    logic [1:0]  cpl_core;
    logic [15:0] cpl_out_addr;
    logic        cpl_error;
    logic [3:0]  pending;
    logic        busy;

    sha256_job_scheduler #(
        .NUM_CORES(4), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_msg_addr(job_msg_addr), .job_out_addr(job_out_addr),
        .core_start(core_start),
        .core_msg_addr(core_msg_addr), .core_out_addr(core_out_addr),
        .core_done(core_done),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready),
        .cpl_core(cpl_core), .cpl_out_addr(cpl_out_addr),
        .cpl_error(cpl_error), .pending(pending), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int         run_len [4] = '{100, 100, 100, 100};
    int         cnt     [4] = '{0, 0, 0, 0};
    logic [3:0] hold  = '0;
    logic [3:0] stuck = '0;

    // engine: done drops after start and stays low for run_len cycles
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset)              cnt[i] <= 0;
            else if (core_start[i]) cnt[i] <= run_len[i];
            else if (cnt[i] > 0)    cnt[i] <= cnt[i] - 1;
        end
    end

    always_comb begin
        core_done = '0;
        for (int i = 0; i < 4; i++)
            core_done[i] = stuck[i] | (!hold[i] && cnt[i] == 0);
    end

    int          st_core [$];
    logic [15:0] st_msg  [$];
    logic [15:0] st_out  [$];
    int          cp_core [$];
    logic [15:0] cp_out  [$];
    logic        cp_err  [$];

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (core_start[i]) begin
                st_core.push_back(i);
                st_msg.push_back(core_msg_addr[16*i +: 16]);
                st_out.push_back(core_out_addr[16*i +: 16]);
            end
        end
        if (cpl_valid && cpl_ready && !reset) begin
            cp_core.push_back(int'(cpl_core));
            cp_out.push_back(cpl_out_addr);
            cp_err.push_back(cpl_error);
        end
    end

    typedef struct {
        logic [15:0] msg;
        logic [15:0] out;
        int          core;
        logic        rdy;
    } vec_t;

    vec_t t2 [9];
    vec_t t3 [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] m, input logic [15:0] o);
        job_valid    = 1'b1;
        job_msg_addr = m;
        job_out_addr = o;
        tick();
        job_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        job_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        st_core.delete(); st_msg.delete(); st_out.delete();
        cp_core.delete(); cp_out.delete(); cp_err.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_job_ready"}, job_ready, 1);
        chk({tag, "_core_start"}, core_start, 0);
        chk({tag, "_core_msg"}, core_msg_addr, 0);
        chk({tag, "_core_out"}, core_out_addr, 0);
        chk({tag, "_cpl_valid"}, cpl_valid, 0);
        chk({tag, "_cpl_core"}, cpl_core, 0);
        chk({tag, "_cpl_out"}, cpl_out_addr, 0);
        chk({tag, "_cpl_error"}, cpl_error, 0);
        chk({tag, "_pending"}, pending, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int n;
        int sum_exp;
        int sum_act;

        for (int j = 0; j < 9; j++)
            t2[j] = '{msg: 16'h1000 + 16'(j), out: 16'h2000 + 16'(j),
                      core: 0, rdy: (j < 8)};
        t3[0] = '{16'h0A00, 16'h0B00, 0, 1'b1};
        t3[1] = '{16'h0A10, 16'h0B10, 1, 1'b1};
        t3[2] = '{16'h0A20, 16'h0B20, 2, 1'b1};
        t3[3] = '{16'h0A30, 16'h0B30, 3, 1'b1};
        t3[4] = '{16'h0A40, 16'h0B40, 0, 1'b1};
        t3[5] = '{16'h0A50, 16'h0B50, 1, 1'b1};

        // reset values
        tick();
        tick();
        chk_reset_vals("rst");
        reset = 1'b0;

        // single job, two-cycle start latency
        push(16'h0000, 16'h0100);
        chk("t1_start_early", core_start, 0);
        tick();
        chk("t1_start", core_start, 4'b0001);
        chk("t1_msg", core_msg_addr[15:0], 16'h0000);
        chk("t1_out", core_out_addr[15:0], 16'h0100);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_start_once", core_start, 0);
        n = 0;
        while (!cpl_valid && n < 200) begin tick(); n++; end
        chk("t1_cpl_valid", cpl_valid, 1);
        chk("t1_cpl_core", cpl_core, 0);
        chk("t1_cpl_out", cpl_out_addr, 16'h0100);
        chk("t1_cpl_err", cpl_error, 0);
        tick();
        chk("t1_cpl_drop", cpl_valid, 0);
        chk("t1_starts", st_core.size(), 1);

        // FIFO full with engines held busy
        do_reset();
        hold = 4'hF;
        for (int j = 0; j < 9; j++) begin
            job_valid    = 1'b1;
            job_msg_addr = t2[j].msg;
            job_out_addr = t2[j].out;
            chk($sformatf("t2_ready_%0d", j), job_ready, t2[j].rdy);
            tick();
        end
        job_valid = 1'b0;
        chk("t2_pending_full", pending, 8);
        chk("t2_ready_full", job_ready, 0);
        hold[0] = 1'b0;
        tick();
        chk("t2_pending_pop", pending, 7);
        chk("t2_ready_pop", job_ready, 1);
        chk("t2_head_msg", core_msg_addr[15:0], t2[0].msg);
        hold = '0;

        // dispatch order and pointer continuation
        do_reset();
        run_len = '{4, 6, 40, 40};
        for (int j = 0; j < 6; j++) begin
            job_valid    = 1'b1;
            job_msg_addr = t3[j].msg;
            job_out_addr = t3[j].out;
            tick();
        end
        job_valid = 1'b0;
        n = 0;
        while (st_core.size() < 6 && n < 100) begin tick(); n++; end
        chk("t3_dispatches", st_core.size(), 6);
        for (int j = 0; j < 6; j++) begin
            int          c;
            logic [15:0] m, o;
            c = (j < st_core.size()) ? st_core[j] : -1;
            m = (j < st_msg.size())  ? st_msg[j]  : 16'hFFFF;
            o = (j < st_out.size())  ? st_out[j]  : 16'hFFFF;
            chk($sformatf("t3_core_%0d", j), c, t3[j].core);
            chk($sformatf("t3_msg_%0d", j), m, t3[j].msg);
            chk($sformatf("t3_out_%0d", j), o, t3[j].out);
        end
        n = 0;
        while (cp_core.size() < 6 && n < 300) begin tick(); n++; end
        chk("t3_cpls", cp_core.size(), 6);
        sum_exp = 0;
        sum_act = 0;
        for (int j = 0; j < 6; j++) sum_exp += int'(t3[j].out);
        for (int j = 0; j < cp_out.size(); j++) begin
            sum_act += int'(cp_out[j]);
            chk($sformatf("t3_err_%0d", j), cp_err[j], 0);
        end
        chk("t3_out_sum", sum_act, sum_exp);

        // simultaneous finishers under backpressure
        do_reset();
        hold    = 4'b0101;
        run_len = '{100, 11, 100, 10};
        cpl_ready = 1'b0;
        push(16'h0010, 16'h0110);
        push(16'h0020, 16'h0120);
        n = 0;
        while (!cpl_valid && n < 60) begin tick(); n++; end
        chk("t4_valid", cpl_valid, 1);
        chk("t4_first_core", cpl_core, 1);
        chk("t4_first_out", cpl_out_addr, 16'h0110);
        for (int k = 0; k < 5; k++) begin
            job_valid    = (k < 2);
            job_msg_addr = (k == 0) ? 16'h0030 : 16'h0040;
            job_out_addr = (k == 0) ? 16'h0130 : 16'h0140;
            tick();
            chk($sformatf("t4_hold_core_%0d", k), cpl_core, 1);
            chk($sformatf("t4_hold_out_%0d", k), cpl_out_addr, 16'h0110);
            chk($sformatf("t4_hold_valid_%0d", k), cpl_valid, 1);
        end
        job_valid = 1'b0;
        chk("t4_no_redispatch", st_core.size(), 2);
        chk("t4_pending", pending, 2);
        cpl_ready = 1'b1;
        tick();
        chk("t4_second_valid", cpl_valid, 1);
        chk("t4_second_core", cpl_core, 3);
        chk("t4_second_out", cpl_out_addr, 16'h0120);
        n = 0;
        while (st_core.size() < 4 && n < 40) begin tick(); n++; end
        chk("t4_redispatch_a", (st_core.size() > 2) ? st_core[2] : -1, 1);
        chk("t4_redispatch_b", (st_core.size() > 3) ? st_core[3] : -1, 3);
        n = 0;
        while (cp_core.size() < 4 && n < 60) begin tick(); n++; end
        chk("t4_cpl_order_a", (cp_core.size() > 0) ? cp_core[0] : -1, 1);
        chk("t4_cpl_order_b", (cp_core.size() > 1) ? cp_core[1] : -1, 3);
        hold = '0;

`ifdef SHA_SCHED_TIMEOUT_EN
        // watchdog on an engine that never drops done
        do_reset();
        hold  = 4'b1011;
        stuck = 4'b0100;
        push(16'h0050, 16'h0150);
        tick();
        chk("t5_start", core_start, 4'b0100);
        n = 0;
        while (!cpl_valid && n < 100) begin tick(); n++; end
        chk("t5_latency", n, 66);
        chk("t5_core", cpl_core, 2);
        chk("t5_error", cpl_error, 1);
        chk("t5_out", cpl_out_addr, 16'h0150);
        tick();
        push(16'h0060, 16'h0160);
        n = 0;
        while (core_start[2] !== 1'b1 && n < 10) begin tick(); n++; end
        chk("t5_redispatch", core_start[2], 1);
        stuck = '0;
        hold  = '0;
`endif

        // reset during a running job with jobs queued
        do_reset();
        hold    = 4'b1110;
        run_len = '{50, 50, 50, 50};
        for (int j = 0; j < 4; j++)
            push(16'h0300 + 16'(j), 16'h0400 + 16'(j));
        repeat (4) tick();
        chk("t6_pending_pre", pending, 3);
        chk("t6_busy_pre", busy, 1);
        reset = 1'b1;
        tick();
        chk_reset_vals("t6");
        reset = 1'b0;
        repeat (80) tick();
        chk("t6_no_cpl", cp_core.size(), 0);
        chk("t6_no_restart", st_core.size(), 1);
        chk("t6_pending_post", pending, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
